wb_regfile_stage: RTL and testbench
===================================

// Module: wb_regfile_stage
// PURPOSE
//  Write-back end of the MEM/WB interface: consumes the MEM/WB pipeline register outputs and
//  selects ALU result vs load data. Commits the result into a 32x32 register file and serves
//  the decode stage's two read ports with same-cycle write bypass.
//  Also exports the committed write (and the previous commit) to the EX forwarding unit, and
//  counts retired instructions.
// PARAMETERS
//  NREGS      32  number of architectural registers (power of two; index width = log2(NREGS))
//  DW         32  data width
//  CNTW       32  retired-instruction counter width
// PORTS
//  clk                    in   1   rising-edge clock
//  rst_n                  in   1   asynchronous active-low reset
//  MemWbValid             in   1   MEM/WB slot holds a real instruction (0 = bubble)
//  MemWbAluOutput         in   DW  ALU result from MEM/WB register
//  MemWbMemoryReadData    in   DW  load data from MEM/WB register
//  MemWbWriteBackDest     in   5   destination register index
//  MemWbwriteRegEnable    in   1   instruction writes a register
//  MemWbwritebackRegCtrl  in   1   1 = write load data, 0 = write ALU result
//  ReadAddr1, ReadAddr2   in   5   decode-stage source register indices
//  ReadData1, ReadData2   out  DW  source operands (combinational, bypassed)
//  WbData                 out  DW  value being committed this cycle (combinational)
//  WbDest                 out  5   dest being committed this cycle
//  WbWriteEn              out  1   commit qualifier: valid & enable & dest!=0
//  PrevWbData             out  DW  value committed in the previous cycle (registered)
//  PrevWbDest             out  5   dest of the previous commit (registered)
//  PrevWbWriteEn          out  1   previous-commit qualifier (registered)
//  RetiredCount           out  CNTW count of valid instructions that reached write-back
// BEHAVIOUR
//  - WbData = MemWbwritebackRegCtrl ? MemWbMemoryReadData : MemWbAluOutput (pure mux, 0 latency).
//  - WbWriteEn = MemWbValid & MemWbwriteRegEnable & (MemWbWriteBackDest != 0).
//  - Commit: at posedge clk, if WbWriteEn, regs[WbDest] <= WbData. One commit per cycle max.
//  - Register 0 is hardwired 0: never written; reads of index 0 return 0 even when bypassing.
//  - Read ports are asynchronous. If WbWriteEn and ReadAddrN == WbDest (nonzero),
//    ReadDataN = WbData (write-before-read bypass); otherwise ReadDataN = regs[ReadAddrN].
//  - Both read ports may hit the same address or the write address simultaneously;
//    each resolves independently under the rule above.
//  - Prev* registers load WbData/WbDest/WbWriteEn every posedge clk (bubbles load WriteEn=0).
//  - RetiredCount increments by 1 on each posedge with MemWbValid=1, regardless of write
//    enable (stores/branches retire too); wraps 2^CNTW-1 -> 0 silently.
//  - Inputs with MemWbValid=0 are don't-care: no commit, no count, WbWriteEn=0.
//  - Reset (rst_n low, async): all regs <= 0, Prev* <= 0, RetiredCount <= 0, immediately.
//    Combinational outputs follow inputs during reset, except that ReadDataN reads 0 from
//    the cleared array. A commit coinciding with reset assertion is dropped.
//    First commit occurs at the first posedge after rst_n deasserts.
// STRUCTURE
//  - Shared package (mips_pkg): REG_IDX_W=5, DATA_W=32, REG_ZERO=5'd0, WB_SEL_ALU=1'b0,
//    WB_SEL_MEM=1'b1.
//  - One sub-module: regfile_2r1w (array, reset clear, r0 forced to zero, bypass on reads).
//  - Top holds the result mux, commit qualifier, Prev* registers, and retire counter.
// TESTING
//  1 Reset: assert rst_n=0 mid-run after writing r5=32'hDEAD -> ReadData1(addr 5)=0,
//    RetiredCount=0, PrevWbWriteEn=0.
//  2 ALU write: valid, en, dest=3, ctrl=0, alu=32'h1234 -> after edge r3 reads 32'h1234;
//    RetiredCount=1.
//  3 Load + bypass: dest=7, ctrl=1, mem=32'hCAFE, ReadAddr1=ReadAddr2=7 in the same cycle ->
//    both read 32'hCAFE before the edge.
//  4 r0 guard: dest=0, alu=32'hFFFF_FFFF, en=1 -> WbWriteEn=0; r0 reads 0; counter still +1.
//  5 Bubble/disabled: valid=0, en=1, dest=4 -> r4 unchanged, no count.
//    valid=1, en=0 -> r4 unchanged, count +1.
//  6 Back-to-back commits r1=1, r2=2, then a bubble -> PrevWb* track (1,1,1), (2,2,1), (x,x,0).
//    Preload RetiredCount near wrap (CNTW=4: 15 valid) -> 16th valid gives 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: register index/data widths and write-back source select codes.
package mips_pkg;
    localparam int          REG_IDX_W  = 5;
    localparam int          DATA_W     = 32;
    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam logic        WB_SEL_ALU = 1'b0;
    localparam logic        WB_SEL_MEM = 1'b1;
endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with async clear, hardwired-zero r0 and write-before-read bypass.
module regfile_2r1w
    import mips_pkg::*;
#(
    parameter  int NREGS = 1 << REG_IDX_W,
    parameter  int DW    = DATA_W,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);
    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];

    // r0 is rewritten to zero every cycle so no write path can ever disturb it.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != AW'(REG_ZERO))) regs_d[waddr] = wdata;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    function automatic logic [DW-1:0] rd_port(input logic [AW-1:0] ra, input logic w_en,
                                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                              input logic [DW-1:0] stored);
        if (ra == AW'(REG_ZERO))    return '0;
        else if (w_en && ra == wa)  return wd;
        else                        return stored;
    endfunction

    always_comb begin
        rdata1 = rd_port(raddr1, we, waddr, wdata, regs_q[raddr1]);
        rdata2 = rd_port(raddr2, we, waddr, wdata, regs_q[raddr2]);
    end
endmodule

// File: rtl/wb_regfile_stage.sv
// Write-back stage: result select, commit into the register file, previous-commit export, retire counter.
module wb_regfile_stage
    import mips_pkg::*;
#(
    parameter  int NREGS = 1 << REG_IDX_W,
    parameter  int DW    = DATA_W,
    parameter  int CNTW  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            MemWbValid,
    input  logic [DW-1:0]   MemWbAluOutput,
    input  logic [DW-1:0]   MemWbMemoryReadData,
    input  logic [AW-1:0]   MemWbWriteBackDest,
    input  logic            MemWbwriteRegEnable,
    input  logic            MemWbwritebackRegCtrl,
    input  logic [AW-1:0]   ReadAddr1,
    input  logic [AW-1:0]   ReadAddr2,
    output logic [DW-1:0]   ReadData1,
    output logic [DW-1:0]   ReadData2,
    output logic [DW-1:0]   WbData,
    output logic [AW-1:0]   WbDest,
    output logic            WbWriteEn,
    output logic [DW-1:0]   PrevWbData,
    output logic [AW-1:0]   PrevWbDest,
    output logic            PrevWbWriteEn,
    output logic [CNTW-1:0] RetiredCount
);
    logic [DW-1:0]   prev_data_q, prev_data_d;
    logic [AW-1:0]   prev_dest_q, prev_dest_d;
    logic            prev_we_q,   prev_we_d;
    logic [CNTW-1:0] ret_cnt_q,   ret_cnt_d;

    always_comb begin
        WbData    = (MemWbwritebackRegCtrl == WB_SEL_MEM) ? MemWbMemoryReadData : MemWbAluOutput;
        WbDest    = MemWbWriteBackDest;
        WbWriteEn = MemWbValid & MemWbwriteRegEnable & (MemWbWriteBackDest != AW'(REG_ZERO));
    end

    regfile_2r1w #(.NREGS(NREGS), .DW(DW)) u_rf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (WbWriteEn),
        .waddr  (WbDest),
        .wdata  (WbData),
        .raddr1 (ReadAddr1),
        .raddr2 (ReadAddr2),
        .rdata1 (ReadData1),
        .rdata2 (ReadData2)
    );

    // Stores and branches retire without writing, so only Valid gates the count.
    always_comb begin
        prev_data_d = WbData;
        prev_dest_d = WbDest;
        prev_we_d   = WbWriteEn;
        ret_cnt_d   = MemWbValid ? ret_cnt_q + CNTW'(1) : ret_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_data_q <= '0;
            prev_dest_q <= '0;
            prev_we_q   <= 1'b0;
            ret_cnt_q   <= '0;
        end else begin
            prev_data_q <= prev_data_d;
            prev_dest_q <= prev_dest_d;
            prev_we_q   <= prev_we_d;
            ret_cnt_q   <= ret_cnt_d;
        end
    end

    assign PrevWbData    = prev_data_q;
    assign PrevWbDest    = prev_dest_q;
    assign PrevWbWriteEn = prev_we_q;
    assign RetiredCount  = ret_cnt_q;
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: spec-level reference model checked every cycle plus literal pins.
module tb_wb_regfile_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, en, ctrl;
    logic [31:0] alu, mem;
    logic [4:0]  dest, ra1, ra2;

    logic [31:0] rd1, rd2, wbd, pwd, cnt;
    logic [4:0]  wbdst, pwdst;
    logic        wbwe, pwe;
    logic [31:0] d4_rd1, d4_rd2, d4_wbd, d4_pwd;
    logic [4:0]  d4_wbdst, d4_pwdst;
    logic        d4_wbwe, d4_pwe;
    logic [3:0]  cnt4;

    int n_pass = 0, n_total = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    wb_regfile_stage dut (
        .clk(clk), .rst_n(rst_n), .MemWbValid(valid), .MemWbAluOutput(alu),
        .MemWbMemoryReadData(mem), .MemWbWriteBackDest(dest), .MemWbwriteRegEnable(en),
        .MemWbwritebackRegCtrl(ctrl), .ReadAddr1(ra1), .ReadAddr2(ra2),
        .ReadData1(rd1), .ReadData2(rd2), .WbData(wbd), .WbDest(wbdst), .WbWriteEn(wbwe),
        .PrevWbData(pwd), .PrevWbDest(pwdst), .PrevWbWriteEn(pwe), .RetiredCount(cnt)
    );

    wb_regfile_stage #(.CNTW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .MemWbValid(valid), .MemWbAluOutput(alu),
        .MemWbMemoryReadData(mem), .MemWbWriteBackDest(dest), .MemWbwriteRegEnable(en),
        .MemWbwritebackRegCtrl(ctrl), .ReadAddr1(ra1), .ReadAddr2(ra2),
        .ReadData1(d4_rd1), .ReadData2(d4_rd2), .WbData(d4_wbd), .WbDest(d4_wbdst),
        .WbWriteEn(d4_wbwe), .PrevWbData(d4_pwd), .PrevWbDest(d4_pwdst),
        .PrevWbWriteEn(d4_pwe), .RetiredCount(cnt4)
    );

    // Reference model: architectural state only.
    logic [31:0] m_regs [32];
    logic [31:0] m_pd;
    logic [4:0]  m_pdst;
    logic        m_pen;
    logic [31:0] m_cnt;

    function automatic logic [31:0] exp_wd();
        return ctrl ? mem : alu;
    endfunction
    function automatic logic exp_we();
        return valid && en && dest != 5'd0;
    endfunction
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (exp_we() && a == dest) return exp_wd();
        return m_regs[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_pd <= 32'd0; m_pdst <= 5'd0; m_pen <= 1'b0; m_cnt <= 32'd0;
        end else begin
            if (exp_we()) m_regs[dest] <= exp_wd();
            m_pd <= exp_wd(); m_pdst <= dest; m_pen <= exp_we();
            if (valid) m_cnt <= m_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("WbData",        wbd,           exp_wd());
            chk("WbWriteEn",     {31'd0, wbwe}, {31'd0, exp_we()});
            chk("WbDest",        {27'd0, wbdst}, {27'd0, dest});
            chk("ReadData1",     rd1,           exp_rd(ra1));
            chk("ReadData2",     rd2,           exp_rd(ra2));
            chk("PrevWbData",    pwd,           m_pd);
            chk("PrevWbDest",    {27'd0, pwdst}, {27'd0, m_pdst});
            chk("PrevWbWriteEn", {31'd0, pwe},  {31'd0, m_pen});
            chk("RetiredCount",  cnt,           m_cnt);
            chk("RetiredCount4", {28'd0, cnt4}, {28'd0, m_cnt[3:0]});
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] m,
                         input logic [4:0] d, input logic e, input logic c,
                         input logic [4:0] r1, input logic [4:0] r2);
        valid = v; alu = a; mem = m; dest = d; en = e; ctrl = c; ra1 = r1; ra2 = r2;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("init_cnt", cnt, 32'd0);
        chk("init_pwe", {31'd0, pwe}, 32'd0);
        @(negedge clk); #1 rst_n = 1'b1;
        chk_en = 1;
        step();

        // ALU write r3
        drive(1, 32'h1234, 32'h0, 5'd3, 1, 0, 5'd0, 5'd0); step();
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 5'd3, 5'd3); #2;
        chk("alu_r3", rd1, 32'h1234);
        chk("alu_cnt", cnt, 32'd1);
        step();

        // Load with same-cycle bypass on both ports
        drive(1, 32'h5555, 32'hCAFE, 5'd7, 1, 1, 5'd7, 5'd7); #2;
        chk("byp_rd1", rd1, 32'hCAFE);
        chk("byp_rd2", rd2, 32'hCAFE);
        step();

        // r0 guard
        drive(1, 32'hFFFF_FFFF, 32'h0, 5'd0, 1, 0, 5'd0, 5'd7); #2;
        chk("r0_we", {31'd0, wbwe}, 32'd0);
        chk("r0_rd", rd1, 32'd0);
        step(); #1;
        chk("r0_cnt", cnt, 32'd3);

        // Bubble and disabled-write on r4
        drive(1, 32'h44, 32'h0, 5'd4, 1, 0, 5'd4, 5'd0); step();
        drive(0, 32'h99, 32'h0, 5'd4, 1, 0, 5'd4, 5'd0); step(); #1;
        chk("bub_r4", rd1, 32'h44);
        chk("bub_cnt", cnt, 32'd4);
        drive(1, 32'h77, 32'h0, 5'd4, 0, 0, 5'd4, 5'd0); step(); #1;
        chk("dis_r4", rd1, 32'h44);
        chk("dis_cnt", cnt, 32'd5);

        // Back-to-back commits and Prev* tracking
        drive(1, 32'd1, 32'h0, 5'd1, 1, 0, 5'd1, 5'd2); step(); #1;
        chk("prev1_d", pwd, 32'd1);
        chk("prev1_a", {27'd0, pwdst}, 32'd1);
        chk("prev1_e", {31'd0, pwe}, 32'd1);
        drive(1, 32'd2, 32'h0, 5'd2, 1, 0, 5'd1, 5'd2); step(); #1;
        chk("prev2_d", pwd, 32'd2);
        chk("prev2_a", {27'd0, pwdst}, 32'd2);
        chk("prev2_e", {31'd0, pwe}, 32'd1);
        drive(0, 32'd9, 32'h0, 5'd9, 0, 0, 5'd1, 5'd2); step(); #1;
        chk("prev3_e", {31'd0, pwe}, 32'd0);
        chk("prev3_cnt", cnt, 32'd7);

        // Mid-run async reset after r5 = DEAD; a commit held during reset is dropped
        drive(1, 32'hDEAD, 32'h0, 5'd5, 1, 0, 5'd5, 5'd0); step(); #1;
        chk("pre_rst_r5", rd1, 32'hDEAD);
        rst_n = 1'b0;
        drive(1, 32'h66, 32'h0, 5'd6, 1, 0, 5'd5, 5'd0); #1;
        chk("rst_r5", rd1, 32'd0);
        chk("rst_cnt", cnt, 32'd0);
        chk("rst_pwe", {31'd0, pwe}, 32'd0);
        step();
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 5'd6, 5'd5); #2;
        rst_n = 1'b1; #1;
        chk("rst_r6_drop", rd1, 32'd0);
        step();

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 15; i++) begin
            drive(1, 32'h0, 32'h0, 5'd0, 0, 0, 5'd0, 5'd0); step();
        end
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 5'd0, 5'd0); #2;
        chk("wrap15", {28'd0, cnt4}, 32'd15);
        drive(1, 32'h0, 32'h0, 5'd0, 0, 0, 5'd0, 5'd0); step();
        drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 5'd0, 5'd0); #2;
        chk("wrap0", {28'd0, cnt4}, 32'd0);
        chk("wrap_cnt32", cnt, 32'd16);
        step(); step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
